// File: rtl/sonic_sysid_pkg.sv
// Shared types and constants for the sysid checker.
// Optional timestamp read is built only when SONIC_SYSID_TS_READ_EN is defined.
package sonic_sysid_pkg;

  localparam logic [31:0] SYSID_DEFAULT_ID = 32'h38D8_FF5B;
  localparam logic        SYSID_ADDR_ID    = 1'b0;
  localparam logic        SYSID_ADDR_TS    = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    REQ_ID,
    WAIT_ID,
`ifdef SONIC_SYSID_TS_READ_EN
    REQ_TS,
    WAIT_TS,
`endif
    FINISH
  } sysid_state_e;

endpackage

// File: rtl/sonic_sysid_timeout.sv
// Saturating read-phase timeout counter for the sysid checker.
// expired flags the edge on which the count reaches TIMEOUT_CYCLES.
module sonic_sysid_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W:0] LIMIT = (CNT_W + 1)'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   count_inc;

  assign count_inc = {1'b0, count} + {{CNT_W{1'b0}}, 1'b1};

  // Must not depend on clear: the FSM derives clear from a next state that uses expired.
  assign expired = enable && (count_inc >= LIMIT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && ({1'b0, count} != LIMIT)) begin
      count <= count_inc[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/sonic_sysid_checker.sv
// Reads the sysid slave over Avalon-MM and compares the ID word with EXPECTED_ID.
// Define SONIC_SYSID_TS_READ_EN to also read the timestamp word at address 1.
module sonic_sysid_checker
  import sonic_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = SYSID_DEFAULT_ID,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        timed_out,
  output logic [31:0] id_value,
  output logic [31:0] timestamp
);

`ifdef SONIC_SYSID_TS_READ_EN
  localparam sysid_state_e AFTER_ID = REQ_TS;
  localparam logic         AFTER_ID_IS_REQ = 1'b1;
`else
  localparam sysid_state_e AFTER_ID = FINISH;
  localparam logic         AFTER_ID_IS_REQ = 1'b0;
`endif

  sysid_state_e state, state_nxt;
  logic         to_clear, to_enable, to_expired;
  logic         cap_id, set_timeout;
`ifdef SONIC_SYSID_TS_READ_EN
  logic         cap_ts;
`endif

  sonic_sysid_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock  (clock),
    .reset  (reset),
    .clear  (to_clear),
    .enable (to_enable),
    .expired(to_expired)
  );

  // Data accepted together with the request wins over expiry; expiry wins over a plain accept.
  always_comb begin
    state_nxt   = state;
    to_clear    = 1'b0;
    to_enable   = 1'b0;
    cap_id      = 1'b0;
    set_timeout = 1'b0;
`ifdef SONIC_SYSID_TS_READ_EN
    cap_ts      = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = REQ_ID;
          to_clear  = 1'b1;
        end
      end
      REQ_ID: begin
        to_enable = 1'b1;
        if (!avm_waitrequest && avm_readdatavalid) begin
          cap_id    = 1'b1;
          state_nxt = AFTER_ID;
          to_clear  = AFTER_ID_IS_REQ;
        end else if (to_expired) begin
          set_timeout = 1'b1;
          state_nxt   = FINISH;
        end else if (!avm_waitrequest) begin
          state_nxt = WAIT_ID;
        end
      end
      WAIT_ID: begin
        to_enable = 1'b1;
        if (avm_readdatavalid) begin
          cap_id    = 1'b1;
          state_nxt = AFTER_ID;
          to_clear  = AFTER_ID_IS_REQ;
        end else if (to_expired) begin
          set_timeout = 1'b1;
          state_nxt   = FINISH;
        end
      end
`ifdef SONIC_SYSID_TS_READ_EN
      REQ_TS: begin
        to_enable = 1'b1;
        if (!avm_waitrequest && avm_readdatavalid) begin
          cap_ts    = 1'b1;
          state_nxt = FINISH;
        end else if (to_expired) begin
          set_timeout = 1'b1;
          state_nxt   = FINISH;
        end else if (!avm_waitrequest) begin
          state_nxt = WAIT_TS;
        end
      end
      WAIT_TS: begin
        to_enable = 1'b1;
        if (avm_readdatavalid) begin
          cap_ts    = 1'b1;
          state_nxt = FINISH;
        end else if (to_expired) begin
          set_timeout = 1'b1;
          state_nxt   = FINISH;
        end
      end
`endif
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      id_ok     <= 1'b0;
      timed_out <= 1'b0;
      id_value  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        id_ok     <= 1'b0;
        timed_out <= 1'b0;
        id_value  <= '0;
      end
      if (cap_id) id_value <= avm_readdata;
      if (set_timeout) timed_out <= 1'b1;
      if (state == FINISH && !timed_out) id_ok <= (id_value == EXPECTED_ID);
    end
  end

`ifdef SONIC_SYSID_TS_READ_EN
  logic [31:0] ts_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ts_q <= '0;
    end else if (state == IDLE && start) begin
      ts_q <= '0;
    end else if (cap_ts) begin
      ts_q <= avm_readdata;
    end
  end

  assign timestamp   = ts_q;
  assign avm_read    = (state == REQ_ID) || (state == REQ_TS);
  assign avm_address = (state == REQ_TS || state == WAIT_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
`else
  assign timestamp   = '0;
  assign avm_read    = (state == REQ_ID);
  assign avm_address = SYSID_ADDR_ID;
`endif

  assign busy = (state != IDLE);
  assign done = (state == FINISH);

endmodule

// File: tb/tb_sonic_sysid_checker.sv
// Directed bench for sonic_sysid_checker with a behavioural Avalon-MM sysid slave.
// Expectations follow SONIC_SYSID_TS_READ_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_sonic_sysid_checker;

  localparam int unsigned TO = 16;
  localparam logic [31:0] GOOD_ID = 32'h38D8_FF5B;
  localparam logic [31:0] TS_A    = 32'h4C00_0000;
  localparam logic [31:0] TS_B    = 32'h1234_5678;

`ifdef SONIC_SYSID_TS_READ_EN
  localparam int          N_READS   = 2;
  localparam logic [31:0] EXP_TS_A  = TS_A;
  localparam logic [31:0] EXP_TS_B  = TS_B;
  localparam logic [31:0] LAST_ADDR = 32'd1;
  localparam int          CYC_A     = 2;
  localparam int          CYC_B     = 4;
  localparam int          CYC_C     = 14;
`else
  localparam int          N_READS   = 1;
  localparam logic [31:0] EXP_TS_A  = 32'h0;
  localparam logic [31:0] EXP_TS_B  = 32'h0;
  localparam logic [31:0] LAST_ADDR = 32'd0;
  localparam int          CYC_A     = 1;
  localparam int          CYC_B     = 2;
  localparam int          CYC_C     = 7;
`endif

  logic        clock = 1'b0;
  logic        reset, start;
  logic        avm_address, avm_read, avm_waitrequest, avm_readdatavalid;
  logic [31:0] avm_readdata;
  logic        busy, done, id_ok, timed_out;
  logic [31:0] id_value, timestamp;

  int checks = 0;
  int errors = 0;

  int          sl_wait = 0;
  int          sl_lat = 0;
  bit          sl_respond = 1'b1;
  logic [31:0] sl_id = GOOD_ID;
  logic [31:0] sl_ts = TS_A;

  int   done_cnt = 0;
  int   stab_err = 0;
  logic acc_q[$];

  always #5 clock = ~clock;

  sonic_sysid_checker #(
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .avm_address      (avm_address),
    .avm_read         (avm_read),
    .avm_waitrequest  (avm_waitrequest),
    .avm_readdata     (avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .busy             (busy),
    .done             (done),
    .id_ok            (id_ok),
    .timed_out        (timed_out),
    .id_value         (id_value),
    .timestamp        (timestamp)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Slave: drives inputs at negedge for the next rising edge.
  initial begin
    int          wait_left;
    int          pend;
    logic [31:0] pend_data;
    logic        was_wait;
    logic        held_addr;
    logic [31:0] data;
    wait_left = 0; pend = 0; pend_data = '0; was_wait = 1'b0; held_addr = 1'b0;
    avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
    forever begin
      @(negedge clock);
      avm_waitrequest   = 1'b0;
      avm_readdatavalid = 1'b0;
      if (was_wait && (avm_read !== 1'b1 || avm_address !== held_addr)) stab_err++;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          avm_readdatavalid = 1'b1;
          avm_readdata      = pend_data;
        end
      end
      if (reset || avm_read !== 1'b1) begin
        wait_left = sl_wait;
        was_wait  = 1'b0;
      end else if (wait_left > 0) begin
        avm_waitrequest = 1'b1;
        wait_left--;
        was_wait  = 1'b1;
        held_addr = avm_address;
      end else begin
        was_wait = 1'b0;
        acc_q.push_back(avm_address);
        data = avm_address ? sl_ts : sl_id;
        if (sl_respond) begin
          if (sl_lat == 0) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = data;
          end else begin
            pend      = sl_lat;
            pend_data = data;
          end
        end
        wait_left = sl_wait;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (done === 1'b1) done_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got hang expected finish");
    $fatal(1, "watchdog");
  end

  task automatic run_seq(input string tag, input int limit, output int cyc);
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < limit) begin
      @(negedge clock);
      cyc++;
    end
    check({tag, "_done_seen"}, done, 1'b1);
  endtask

  initial begin
    int cyc, d0, a0, s0;
    reset = 1'b1; start = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_read", avm_read, 1'b0);
    check("rst_addr", avm_address, 1'b0);
    check("rst_id_ok", id_ok, 1'b0);
    check("rst_timed_out", timed_out, 1'b0);
    check("rst_id_value", id_value, 32'h0);
    check("rst_timestamp", timestamp, 32'h0);
    reset = 1'b0;
    @(negedge clock);

    // Zero-wait, zero-latency slave
    sl_wait = 0; sl_lat = 0; sl_respond = 1'b1; sl_id = GOOD_ID; sl_ts = TS_A;
    d0 = done_cnt; a0 = acc_q.size();
    run_seq("a", 50, cyc);
    check("a_cycles", cyc, CYC_A);
    repeat (3) @(negedge clock);
    check("a_done_cnt", done_cnt - d0, 1);
    check("a_reads", acc_q.size() - a0, N_READS);
    check("a_first_addr", acc_q[a0], 1'b0);
    check("a_last_addr", acc_q[$], LAST_ADDR);
    check("a_id_ok", id_ok, 1'b1);
    check("a_id_value", id_value, GOOD_ID);
    check("a_timestamp", timestamp, EXP_TS_A);
    check("a_timed_out", timed_out, 1'b0);
    check("a_busy", busy, 1'b0);

    // Wrong ID, one-cycle read latency
    sl_wait = 0; sl_lat = 1; sl_id = 32'h0; sl_ts = TS_B;
    d0 = done_cnt;
    run_seq("b", 50, cyc);
    check("b_cycles", cyc, CYC_B);
    repeat (3) @(negedge clock);
    check("b_done_cnt", done_cnt - d0, 1);
    check("b_id_ok", id_ok, 1'b0);
    check("b_id_value", id_value, 32'h0);
    check("b_timestamp", timestamp, EXP_TS_B);
    check("b_timed_out", timed_out, 1'b0);

    // Five waitrequest cycles on every read
    sl_wait = 5; sl_lat = 1; sl_id = GOOD_ID; sl_ts = TS_A;
    d0 = done_cnt; a0 = acc_q.size(); s0 = stab_err;
    run_seq("c", 60, cyc);
    check("c_cycles", cyc, CYC_C);
    repeat (3) @(negedge clock);
    check("c_stable", stab_err - s0, 0);
    check("c_reads", acc_q.size() - a0, N_READS);
    check("c_id_ok", id_ok, 1'b1);
    check("c_timestamp", timestamp, EXP_TS_A);
    check("c_timed_out", timed_out, 1'b0);

    // No readdatavalid: timeout in WAIT_ID
    sl_wait = 0; sl_lat = 1; sl_respond = 1'b0;
    d0 = done_cnt;
    run_seq("d", 60, cyc);
    check("d_cycles", cyc, 16);
    check("d_read_at_done", avm_read, 1'b0);
    check("d_timed_out_at_done", timed_out, 1'b1);
    repeat (3) @(negedge clock);
    check("d_done_cnt", done_cnt - d0, 1);
    check("d_timed_out", timed_out, 1'b1);
    check("d_id_ok", id_ok, 1'b0);
    check("d_id_value", id_value, 32'h0);

    // Request never accepted: timeout in REQ_ID drops avm_read
    sl_wait = 1000;
    run_seq("d2", 60, cyc);
    check("d2_cycles", cyc, 16);
    check("d2_read_at_done", avm_read, 1'b0);
    repeat (3) @(negedge clock);
    check("d2_timed_out", timed_out, 1'b1);
    check("d2_id_ok", id_ok, 1'b0);

    // start re-pulsed while busy
    sl_wait = 3; sl_lat = 1; sl_respond = 1'b1; sl_id = GOOD_ID; sl_ts = TS_A;
    repeat (2) @(negedge clock);
    d0 = done_cnt; a0 = acc_q.size();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(negedge clock);
    check("e_busy", busy, 1'b1);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (40) @(negedge clock);
    check("e_done_cnt", done_cnt - d0, 1);
    check("e_reads", acc_q.size() - a0, N_READS);
    check("e_id_ok", id_ok, 1'b1);
    check("e_timed_out", timed_out, 1'b0);

    // Reset in the last wait state, then a late readdatavalid
    sl_wait = 0; sl_lat = 4;
    d0 = done_cnt;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cyc = 0;
`ifdef SONIC_SYSID_TS_READ_EN
    while (!(busy === 1'b1 && avm_read === 1'b0 && avm_address === 1'b1) && cyc < 40) begin
`else
    while (!(busy === 1'b1 && avm_read === 1'b0) && cyc < 40) begin
`endif
      @(negedge clock);
      cyc++;
    end
    check("f_wait_state_seen", (cyc < 40), 1'b1);
    reset = 1'b1;
    @(negedge clock);
    check("f_rst_busy", busy, 1'b0);
    check("f_rst_read", avm_read, 1'b0);
    check("f_rst_addr", avm_address, 1'b0);
    check("f_rst_id_value", id_value, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    check("f_done_cnt", done_cnt - d0, 0);
    check("f_busy", busy, 1'b0);
    check("f_id_value", id_value, 32'h0);
    check("f_timestamp", timestamp, 32'h0);
    check("f_id_ok", id_ok, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
